// File: rtl/multiexp_pkg.sv
// rtl/multiexp_pkg.sv - shared multiexp types: field/point types, replay FSM states, pair packing
package multiexp_pkg;

  localparam int FE_BITS = 256;

  // Field element (scalar) and affine/projective point made of three coordinates
  typedef logic [FE_BITS-1:0] fe_t;
  typedef struct packed {
    fe_t x;
    fe_t y;
    fe_t z;
  } fp_t;

  // Replay buffer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_REPLAY = 2'd2;

  // Stream word layout: point in the MSBs, scalar in the LSBs
  function automatic logic [$bits(fp_t)+$bits(fe_t)-1:0] pack_pnt_scl(input fp_t pnt, input fe_t scl);
    return {pnt, scl};
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// rtl/if_axi_stream.sv - valid/ready stream bundle with sop/eop/err/mod sideband
interface if_axi_stream #(
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 6
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/multiexp_replay_ram.sv
// rtl/multiexp_replay_ram.sv - simple dual-port RAM, one write port, one registered read port
module multiexp_replay_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int A_BITS = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [A_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_dat,
  input  logic              rd_en,
  input  logic [A_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // Registered read port, one cycle latency
  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/multiexp_replay_buffer.sv
// rtl/multiexp_replay_buffer.sv - stores one job of point/scalar pairs and replays it KEY_BITS times
module multiexp_replay_buffer
  import multiexp_pkg::*;
#(
  parameter int P_BITS   = $bits(fp_t),
  parameter int S_BITS   = $bits(fe_t),
  parameter int KEY_BITS = S_BITS,
  parameter int MAX_NUM  = 1024,
  parameter int CTL_BITS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [63:0]  i_num_in,
  if_axi_stream.sink   i_pnt_scl_if,
  if_axi_stream.source o_pnt_scl_if,
  output logic         o_busy,
  output logic         o_err
);

  localparam int D_BITS = P_BITS + S_BITS;
  localparam int W_BITS = D_BITS + CTL_BITS;
  localparam int A_BITS = $clog2(MAX_NUM);
  localparam int R_BITS = $clog2(KEY_BITS) + 1;

  state_t              state;
  logic [A_BITS:0]     num_q;
  logic [A_BITS-1:0]   last_addr;
  logic [A_BITS-1:0]   wr_addr;
  logic [A_BITS-1:0]   rd_addr;
  logic [R_BITS-1:0]   round;
  logic                issue_done;

  logic                num_ok;
  logic                in_fire;
  logic                pop;
  logic                rd_en;
  logic                at_last_addr;
  logic                at_last_round;
  logic [2:0]          occ;
  logic [W_BITS-1:0]   ram_rd;

  // Read issued last cycle; its RAM word is on ram_rd now
  logic                pend;
  logic                pend_sop;
  logic                pend_eop;
  logic                pend_last;

  // Output register
  logic                oval;
  logic                osop;
  logic                oeop;
  logic                olast;
  logic [D_BITS-1:0]   odat;
  logic [CTL_BITS-1:0] octl;

  // Skid register, only occupied while the output register is stalled
  logic                sval;
  logic                ssop;
  logic                seop;
  logic                slast;
  logic [D_BITS-1:0]   sdat;
  logic [CTL_BITS-1:0] sctl;

  logic                unused_in;

  // Job framing comes from the beat count only, so input sideband is dropped
  assign unused_in = ^{i_pnt_scl_if.sop, i_pnt_scl_if.eop, i_pnt_scl_if.err, i_pnt_scl_if.mod};

  // Full 64-bit range check so large counts cannot alias into range after truncation
  assign num_ok        = (i_num_in != 64'd0) && (i_num_in <= 64'(MAX_NUM));
  assign last_addr     = A_BITS'(num_q - 1'b1);
  assign in_fire       = (state == ST_LOAD) && i_pnt_scl_if.val;
  assign pop           = oval && o_pnt_scl_if.rdy;
  assign at_last_addr  = (rd_addr == last_addr);
  assign at_last_round = (round == R_BITS'(KEY_BITS - 1));

  // Entries held after this cycle; a new read is only issued if its data will have a slot
  assign occ   = 3'(oval) + 3'(sval) + 3'(pend) - 3'(pop);
  assign rd_en = (state == ST_REPLAY) && !issue_done && (occ < 3'd2);

  assign i_pnt_scl_if.rdy = (state == ST_LOAD);
  assign o_pnt_scl_if.val = oval;
  assign o_pnt_scl_if.sop = osop;
  assign o_pnt_scl_if.eop = oeop;
  assign o_pnt_scl_if.err = 1'b0;
  assign o_pnt_scl_if.mod = '0;
  assign o_pnt_scl_if.dat = odat;
  assign o_pnt_scl_if.ctl = octl;
  assign o_busy           = (state != ST_IDLE);

  multiexp_replay_ram #(
    .WIDTH (W_BITS),
    .DEPTH (MAX_NUM)
  ) u_ram (
    .clk     (i_clk),
    .wr_en   (in_fire),
    .wr_addr (wr_addr),
    .wr_dat  ({i_pnt_scl_if.ctl, i_pnt_scl_if.dat}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (ram_rd)
  );

  // Job FSM with write/read address and round counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      num_q      <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      round      <= '0;
      issue_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          num_q      <= i_num_in[A_BITS:0];
          wr_addr    <= '0;
          rd_addr    <= '0;
          round      <= '0;
          issue_done <= 1'b0;
          if (i_pnt_scl_if.val && num_ok && !oval) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (in_fire) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == last_addr) state <= ST_REPLAY;
          end
        end
        ST_REPLAY: begin
          if (rd_en) begin
            if (at_last_addr) begin
              rd_addr <= '0;
              round   <= round + 1'b1;
              if (at_last_round) issue_done <= 1'b1;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
          if (pop && olast) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Rejected-job pulse, repeated every cycle a bad count is presented
  always_ff @(posedge i_clk) begin
    if (i_rst) o_err <= 1'b0;
    else       o_err <= (state == ST_IDLE) && i_pnt_scl_if.val && !num_ok;
  end

  // Framing of the read in flight, aligned with the RAM output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend      <= 1'b0;
      pend_sop  <= 1'b0;
      pend_eop  <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      pend      <= rd_en;
      pend_sop  <= (rd_addr == '0);
      pend_eop  <= at_last_addr;
      pend_last <= at_last_addr && at_last_round;
    end
  end

  // Output and skid registers: RAM data lands in output if free, else in skid
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      oval  <= 1'b0;
      osop  <= 1'b0;
      oeop  <= 1'b0;
      olast <= 1'b0;
      odat  <= '0;
      octl  <= '0;
      sval  <= 1'b0;
      ssop  <= 1'b0;
      seop  <= 1'b0;
      slast <= 1'b0;
      sdat  <= '0;
      sctl  <= '0;
    end else if (!oval || pop) begin
      if (sval) begin
        oval  <= 1'b1;
        osop  <= ssop;
        oeop  <= seop;
        olast <= slast;
        odat  <= sdat;
        octl  <= sctl;
        sval  <= pend;
        ssop  <= pend_sop;
        seop  <= pend_eop;
        slast <= pend_last;
        sdat  <= ram_rd[D_BITS-1:0];
        sctl  <= ram_rd[W_BITS-1:D_BITS];
      end else begin
        oval  <= pend;
        osop  <= pend_sop;
        oeop  <= pend_eop;
        olast <= pend_last;
        odat  <= ram_rd[D_BITS-1:0];
        octl  <= ram_rd[W_BITS-1:D_BITS];
      end
    end else if (pend) begin
      sval  <= 1'b1;
      ssop  <= pend_sop;
      seop  <= pend_eop;
      slast <= pend_last;
      sdat  <= ram_rd[D_BITS-1:0];
      sctl  <= ram_rd[W_BITS-1:D_BITS];
    end
  end

endmodule

// File: tb/tb_multiexp_replay_buffer.sv
// tb/tb_multiexp_replay_buffer.sv - directed self-checking bench for multiexp_replay_buffer
module tb_multiexp_replay_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a_num;
  logic [63:0] b_num;
  logic        a_busy, a_err, b_busy, b_err;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int rdy_mode = 0;

  logic [63:0] a_q[$];
  logic [63:0] b_q[$];
  int          a_cyc[$];
  int          b_cyc[$];
  int          a_in_cyc[$];
  logic        a_stall = 1'b0;
  logic [63:0] a_hold  = '0;

  if_axi_stream #(.DAT_BITS(48), .CTL_BITS(8)) a_in ();
  if_axi_stream #(.DAT_BITS(48), .CTL_BITS(8)) a_out ();
  if_axi_stream #(.DAT_BITS(48), .CTL_BITS(8)) b_in ();
  if_axi_stream #(.DAT_BITS(48), .CTL_BITS(8)) b_out ();

  always #5 clk = ~clk;

  multiexp_replay_buffer #(
    .P_BITS(32), .S_BITS(16), .KEY_BITS(4), .MAX_NUM(4), .CTL_BITS(8)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_num_in(a_num),
    .i_pnt_scl_if(a_in), .o_pnt_scl_if(a_out),
    .o_busy(a_busy), .o_err(a_err)
  );

  multiexp_replay_buffer #(
    .P_BITS(32), .S_BITS(16), .KEY_BITS(2), .MAX_NUM(8), .CTL_BITS(8)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_num_in(b_num),
    .i_pnt_scl_if(b_in), .o_pnt_scl_if(b_out),
    .o_busy(b_busy), .o_err(b_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_beat(input int id, input bit sop, input bit eop);
    logic [31:0] p;
    logic [15:0] s;
    p = 32'hA000_0000 + 32'(id);
    s = 16'h5000 + 16'(id);
    return {6'b0, sop, eop, 8'(id), p, s};
  endfunction

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    a_out.rdy  <= (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Beat collectors and hold-while-stalled checker, sampled mid-cycle
  always @(negedge clk) begin
    if (a_out.val === 1'b1 && a_out.rdy === 1'b1) begin
      a_q.push_back({6'b0, a_out.sop, a_out.eop, a_out.ctl, a_out.dat});
      a_cyc.push_back(cyc);
    end
    if (a_in.val === 1'b1 && a_in.rdy === 1'b1) a_in_cyc.push_back(cyc);
    if (b_out.val === 1'b1 && b_out.rdy === 1'b1) begin
      b_q.push_back({6'b0, b_out.sop, b_out.eop, b_out.ctl, b_out.dat});
      b_cyc.push_back(cyc);
    end
    if (a_stall) begin
      check("stall val held", a_out.val, 1);
      check("stall beat held", {6'b0, a_out.sop, a_out.eop, a_out.ctl, a_out.dat}, a_hold);
    end
    a_stall <= (a_out.val === 1'b1) && (a_out.rdy !== 1'b1);
    a_hold  <= {6'b0, a_out.sop, a_out.eop, a_out.ctl, a_out.dat};
  end

  task automatic send_a(input int n, input int base);
    logic [63:0] v;
    int t;
    a_num = 64'(n);
    for (int i = 0; i < n; i++) begin
      v = exp_beat(base + i, 1'b0, 1'b0);
      a_in.dat = v[47:0];
      a_in.ctl = v[55:48];
      a_in.sop = 1'b1;
      a_in.err = 1'b1;
      a_in.val = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (a_in.rdy !== 1'b1 && t < 300);
      if (a_in.rdy !== 1'b1) begin
        check("load a timeout", a_in.rdy, 1);
        a_in.val = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    a_in.val = 1'b0;
  endtask

  task automatic send_b(input int n, input int base);
    logic [63:0] v;
    int t;
    b_num = 64'(n);
    for (int i = 0; i < n; i++) begin
      v = exp_beat(base + i, 1'b0, 1'b0);
      b_in.dat = v[47:0];
      b_in.ctl = v[55:48];
      b_in.val = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (b_in.rdy !== 1'b1 && t < 300);
      if (b_in.rdy !== 1'b1) begin
        check("load b timeout", b_in.rdy, 1);
        b_in.val = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    b_in.val = 1'b0;
  endtask

  task automatic wait_out_a(input int n, input string tag);
    int t = 0;
    while (a_q.size() < n && t < 400) begin @(negedge clk); #1; t++; end
    repeat (4) @(negedge clk);
    #1;
    check({tag, " beat count"}, 64'(a_q.size()), 64'(n));
    check({tag, " busy after"}, a_busy, 0);
  endtask

  task automatic check_seq(input string tag, input logic [63:0] q[$], input int off,
                           input int n, input int base, input int key);
    for (int r = 0; r < key; r++) begin
      for (int i = 0; i < n; i++) begin
        int k;
        k = off + r * n + i;
        check($sformatf("%s r%0d i%0d", tag, r, i),
              (k < q.size()) ? q[k] : 64'hdead_dead_dead_dead,
              exp_beat(base + i, i == 0, i == n - 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    a_num = '0; b_num = '0;
    a_in.val = 1'b0; a_in.sop = 1'b0; a_in.eop = 1'b0; a_in.err = 1'b0;
    a_in.mod = '0; a_in.dat = '0; a_in.ctl = '0;
    b_in.val = 1'b0; b_in.sop = 1'b0; b_in.eop = 1'b0; b_in.err = 1'b0;
    b_in.mod = '0; b_in.dat = '0; b_in.ctl = '0;
    b_out.rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out val", a_out.val, 0);
    check("reset sop/eop", {a_out.sop, a_out.eop}, 0);
    check("reset in rdy", a_in.rdy, 0);
    check("reset busy", a_busy, 0);
    check("reset err", a_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Three pairs, four rounds, always ready: back-to-back beats
    a_q.delete(); a_cyc.delete();
    send_a(3, 'h10);
    wait_out_a(12, "basic");
    check_seq("basic", a_q, 0, 3, 'h10, 4);
    check("basic no bubble", (a_cyc.size() == 12) ? 64'(a_cyc[11] - a_cyc[0]) : 64'hffff, 11);

    // Same job with random output backpressure
    rdy_mode = 1;
    a_q.delete(); a_cyc.delete();
    send_a(3, 'h20);
    wait_out_a(12, "stall");
    check_seq("stall", a_q, 0, 3, 'h20, 4);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Rejected counts: zero, MAX_NUM+1, and a count that would alias after truncation
    a_q.delete();
    foreach (a_q[i]) a_q.delete(i);
    for (int c = 0; c < 3; c++) begin
      logic [63:0] bad;
      bad = (c == 0) ? 64'd0 : (c == 1) ? 64'd5 : 64'h1_0000_0003;
      a_num = bad;
      a_in.val = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check($sformatf("reject%0d err k%0d", c, k), a_err, 1);
        check($sformatf("reject%0d in rdy k%0d", c, k), a_in.rdy, 0);
      end
      a_in.val = 1'b0;
      @(posedge clk); #1;
      check($sformatf("reject%0d err drop", c), a_err, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("reject no output", 64'(a_q.size()), 0);
    check("reject busy", a_busy, 0);

    // Full-depth job on the KEY_BITS=2 instance, wrap must be bubble-free
    b_q.delete(); b_cyc.delete();
    send_b(8, 'h40);
    begin
      int t = 0;
      while (b_q.size() < 16 && t < 400) begin @(negedge clk); #1; t++; end
      repeat (4) @(negedge clk);
      #1;
    end
    check("full beat count", 64'(b_q.size()), 16);
    check_seq("full", b_q, 0, 8, 'h40, 2);
    check("full no bubble", (b_cyc.size() == 16) ? 64'(b_cyc[15] - b_cyc[0]) : 64'hffff, 15);
    check("full busy after", b_busy, 0);

    // Reset after the fifth replay beat, then a fresh two-pair job
    a_q.delete();
    send_a(3, 'h30);
    begin
      int t = 0;
      while (a_q.size() < 5 && t < 200) begin @(negedge clk); #1; t++; end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort out val", a_out.val, 0);
    check("abort busy", a_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort no more beats", 64'(a_q.size()), 0);
    send_a(2, 'h50);
    wait_out_a(8, "after abort");
    check_seq("after abort", a_q, 0, 2, 'h50, 4);

    // Back-to-back jobs: second load waits for first job to drain
    a_q.delete(); a_cyc.delete(); a_in_cyc.delete();
    send_a(2, 'h60);
    send_a(1, 'h70);
    wait_out_a(12, "b2b");
    check_seq("b2b job1", a_q, 0, 2, 'h60, 4);
    check_seq("b2b job2", a_q, 8, 1, 'h70, 4);
    check("b2b load after drain",
          (a_in_cyc.size() > 2 && a_cyc.size() > 7) ? 64'(a_in_cyc[2] > a_cyc[7]) : 64'd0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/multiexp_replay_buffer.md
MULTIEXP_REPLAY_BUFFER -- requirements
Module: multiexp_replay_buffer

Interface
REQ-001 SHALL have parameter P_BITS, default 768: point width in bits.
REQ-002 SHALL have parameter S_BITS, default 256: scalar width in bits.
REQ-003 SHALL have parameter KEY_BITS, default S_BITS: number of replay rounds per job.
REQ-004 SHALL have parameter MAX_NUM, default 1024, power of 2: buffer depth in point/scalar pairs.
REQ-005 SHALL have parameter CTL_BITS, default 8: sideband ctl width.
REQ-006 SHALL have port i_clk, input, 1 bit: clock.
REQ-007 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port i_num_in, input, 64 bits: pairs per job, sampled at job start.
REQ-009 SHALL have port i_pnt_scl_if, if_axi_stream sink, P_BITS+S_BITS data (point in MSBs, scalar in LSBs) plus CTL_BITS ctl: input pairs.
REQ-010 SHALL have port o_pnt_scl_if, if_axi_stream source, same widths: replayed pairs to the multiexp stage.
REQ-011 SHALL have port o_busy, output, 1 bit: high whenever state != IDLE.
REQ-012 SHALL have port o_err, output, 1 bit: one-cycle pulse on a rejected job.

Function
REQ-013 SHALL implement states IDLE, LOAD and REPLAY.
REQ-014 IDLE SHALL sample i_num_in into num_q every cycle and hold i_pnt_scl_if.rdy low.
REQ-015 In IDLE with i_pnt_scl_if.val=1, num_in in 1..MAX_NUM and o_pnt_scl_if.val=0: the block SHALL go to LOAD next cycle.
REQ-016 In IDLE with i_pnt_scl_if.val=1 and i_num_in=0 or i_num_in>MAX_NUM: the block SHALL pulse o_err for 1 cycle, stay in IDLE, consume no data, and re-pulse o_err each cycle the condition persists.
REQ-017 LOAD SHALL drive i_pnt_scl_if.rdy=1 and write each accepted beat (dat, ctl) to RAM at wr_addr, with wr_addr incrementing from 0.
REQ-018 LOAD SHALL ignore sop/eop/err/mod on the input; the beat count alone delimits the job.
REQ-019 On acceptance of beat num_q-1, LOAD SHALL drop rdy the next cycle and go to REPLAY, with rd_addr=0 and round=0.
REQ-020 REPLAY SHALL emit pairs 0..num_q-1 in write order, repeated KEY_BITS times, for exactly KEY_BITS*num_q output beats.
REQ-021 Output sop SHALL be 1 on the first beat of each round; eop SHALL be 1 on the last beat of each round; err=0 and mod=0 on every beat; ctl SHALL be the stored ctl.
REQ-022 The RAM SHALL be synchronous-read with 1-cycle latency; first o_pnt_scl_if.val SHALL assert no later than 2 cycles after entering REPLAY.
REQ-023 The output SHALL obey AXI-stream rules: once val=1, dat/ctl/sop/eop stay stable until rdy=1; val SHALL never depend combinationally on rdy.
REQ-024 With rdy held high, REPLAY SHALL sustain 1 beat/cycle, including across round wrap (rd_addr num_q-1 -> 0, round+1) with no bubble.
REQ-025 Backpressure SHALL lose or duplicate no beat; a prefetch/skid register of at most 2 entries is the permitted means.
REQ-026 After the final beat (round KEY_BITS-1, index num_q-1) is accepted, the block SHALL return to IDLE the next cycle.
REQ-027 num_q=1 SHALL produce KEY_BITS beats, each with sop=eop=1.
REQ-028 Round counter width SHALL be $clog2(KEY_BITS)+1 and address width $clog2(MAX_NUM); the 64-bit num_in SHALL be compared at full width before truncation.

Reset
REQ-029 On reset: state=IDLE, o_pnt_scl_if.val=0, sop=eop=0, i_pnt_scl_if.rdy=0, o_busy=0, o_err=0, all counters 0.
REQ-030 Reset asserted mid-LOAD or mid-REPLAY SHALL abort the job with no further output beats; RAM contents need not be cleared.

Structure
REQ-031 The shared multiexp package SHALL hold the state enum and the point/scalar packing convention (point MSBs, scalar LSBs); P_BITS/S_BITS SHALL be derived from FP_TYPE/FE_TYPE at instantiation.
REQ-032 The buffer SHALL be a single sub-module, a simple dual-port RAM (one write port, one registered read port), named multiexp_replay_ram.

Verification
REQ-033 KEY_BITS=4, num_in=3, pairs A,B,C, rdy=1: the output SHALL be A,B,C x4 over 12 consecutive cycles, with sop on A and eop on C each round.
REQ-034 Same job with random 50% output rdy: the same 12-beat sequence SHALL appear, with data held stable while stalled.
REQ-035 num_in=0 and num_in=MAX_NUM+1 with input val=1: o_err SHALL pulse, input rdy SHALL stay 0, and there SHALL be no output.
REQ-036 num_in=MAX_NUM, KEY_BITS=2: the output SHALL be 2*MAX_NUM beats in order, with the wrap at index MAX_NUM-1 -> 0 bubble-free.
REQ-037 Reset asserted after the 5th replay beat, then a new num_in=2 job: the output SHALL carry only the new job's 2*KEY_BITS beats.
REQ-038 Two back-to-back jobs (num_in=2, then num_in=1): the second load SHALL begin only after the first job's final beat is accepted, and both output sequences SHALL be exact.
